alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU command interface. Accepts one instruction plus its two register operands over a valid/ready handshake and decodes it into an ALU command and operands.
- Drives those onto the ALU's A/B/command inputs and holds them stable for ALU_LAT cycles. It then samples result/zero and returns them, with the branch decision, over a second valid/ready handshake.
- Sits between the register-read stage and the ALU in the multi-cycle datapath.

Parameters:
- ALU_LAT, 1, cycles operands are held before result/zero are sampled; legal range 1..15.
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  issuer can accept
- instr  in  32  MIPS instruction word
- rs_val  in  32  value of register rs
- rt_val  in  32  value of register rt
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_command  out  3  0=ADD 1=SUB 2=XOR 3=SLT
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- out_result  out  32  captured result
- out_zero  out  1  captured zero flag
- out_take_branch  out  1  branch decision
- out_illegal  out  1  instruction not decodable

Behaviour:
- Decode, R-type (opcode 0x00):
  - funct 0x20/0x21 -> ADD, A=rs, B=rt
  - 0x22/0x23 -> SUB
  - 0x26 -> XOR
  - 0x2A -> SLT
  - any other funct -> illegal
- Decode, I-type:
  - 0x08 addi -> ADD, B=sign-extended imm16
  - 0x0A slti -> SLT, B=sign-extended imm16
  - 0x0E xori -> XOR, B=zero-extended imm16
  - 0x04 beq, 0x05 bne -> SUB, B=rt
  - any other opcode -> illegal
- States: IDLE, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T0: register alu_a/alu_b/alu_command, load counter=ALU_LAT-1, go to WAIT.
  - If the instruction is illegal: go straight to RESP with out_result=0, out_zero=0, out_take_branch=0, out_illegal=1. The ALU ports keep their previous values.
- WAIT:
  - in_ready=0; alu_* held constant.
  - Counter decrements each cycle. At the edge where counter==0: capture out_result=alu_result and out_zero=alu_zero.
  - out_take_branch = beq ? alu_zero : bne ? ~alu_zero : 0. out_illegal=0. Go to RESP.
  - With ALU_LAT=1, capture happens at T0+1.
- RESP:
  - out_valid=1; all out_* stable while out_ready=0.
  - On out_ready, return to IDLE at that edge. The next instruction can be accepted on the following cycle; no overlap.
- Throughput: one instruction per ALU_LAT+2 cycles when out_ready is held high.
- Reset (rst_n=0 at an edge):
  - state=IDLE; in_ready=0 while rst_n is low; out_valid=0.
  - alu_a, alu_b, alu_command, out_result = 0; out_zero, out_take_branch, out_illegal = 0.
- Reset mid-operation aborts the operation; no response is produced for the aborted instruction.
- out_valid never deasserts without out_ready, except on reset.
- alu_* change only at an accept edge.

Optional Feature:
- Macro ALU_SHADOW_CHECK_EN.
- When defined:
  - Adds output out_mismatch (1 bit).
  - At capture, computes a local reference: A+B, A-B, A^B, or signed A<B ? 1 : 0.
  - out_mismatch=1 if alu_result differs from the reference, or if alu_zero != (reference==0).
  - out_mismatch is held with the other out_* and is 0 for illegal instructions and after reset.
- When not defined: the port is absent and no comparison logic exists.

Decomposition:
- Package alu_ctrl_pkg holds:
  - command encodings ALU_ADD=0, ALU_SUB=1, ALU_XOR=2, ALU_SLT=3
  - opcode/funct constants
  - state enum (IDLE, WAIT, RESP)
  - branch-type enum (NONE, BEQ, BNE)
- Sub-module alu_op_decode: purely combinational. Maps instr, rs_val and rt_val to command, a, b, branch type and illegal. The FSM stays in alu_op_issuer.

Test Plan:
- Add: R-type add with rs=5, rt=7 and ALU_LAT=1 -> alu_command=0, a=5, b=7. With an ideal ALU model, out_result=12, out_zero=0, out_valid at T0+1.
- Slti: opcode 0x0A with imm=0xFFFF and rs=0xFFFFFFFE -> alu_b=0xFFFFFFFF, alu_command=3, out_result=1.
- Branch: beq with rs=rt=0x1234 -> command=1, out_zero=1, out_take_branch=1. Bne with the same operands -> out_take_branch=0.
- Illegal: opcode 0x3F -> out_valid at T0 (next cycle), out_illegal=1, out_result=0, alu_* unchanged.
- Backpressure: out_ready held low for 5 cycles -> out_valid and out_* stable, in_ready=0. Then rst_n low for 1 cycle -> out_valid=0, all outputs 0. The first accept after reset proceeds normally.
- With ALU_SHADOW_CHECK_EN: the ALU model returns 0 for xor of 0xF0F0 and 0x0F0F -> out_mismatch=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU command encodings, MIPS opcode/funct constants, FSM and branch enums
package alu_ctrl_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {NONE, BEQ, BNE} br_t;
  function automatic logic [31:0] alu_ref(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    return cmd == ALU_ADD ? a + b : cmd == ALU_SUB ? a - b : cmd == ALU_XOR ? a ^ b :
           {31'd0, $signed(a) < $signed(b)};
  endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational MIPS decode into ALU command, operands and branch type
// ports: instr/rs_val/rt_val in; cmd, a, b, br, illegal out
module alu_op_decode import alu_ctrl_pkg::*; (
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [2:0]  cmd,
  output logic [31:0] a,
  output logic [31:0] b,
  output br_t         br,
  output logic        illegal
);
  logic [31:0] sext;
  logic unused_fields;
  assign sext = {{16{instr[15]}}, instr[15:0]};
  // register numbers / rd / shamt are resolved upstream; operands arrive as values
  assign unused_fields = ^instr[25:16];
  always_comb begin
    a = rs_val;
    b = rt_val;
    cmd = ALU_ADD;
    br = NONE;
    illegal = 1'b0;
    case (instr[31:26])
      OP_RTYPE:
        case (instr[5:0])
          FN_ADD, FN_ADDU: cmd = ALU_ADD;
          FN_SUB, FN_SUBU: cmd = ALU_SUB;
          FN_XOR: cmd = ALU_XOR;
          FN_SLT: cmd = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      OP_ADDI: b = sext;
      OP_SLTI: begin
        cmd = ALU_SLT;
        b = sext;
      end
      OP_XORI: begin
        cmd = ALU_XOR;
        b = {16'd0, instr[15:0]};
      end
      OP_BEQ: begin
        cmd = ALU_SUB;
        br = BEQ;
      end
      OP_BNE: begin
        cmd = ALU_SUB;
        br = BNE;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: decodes an instruction, holds ALU inputs ALU_LAT cycles, returns result/zero/branch
// ports: clk, rst_n (sync, active-low); in_valid/in_ready + instr/rs_val/rt_val request;
//        alu_a/alu_b/alu_command to ALU, alu_result/alu_zero back;
//        out_valid/out_ready + out_result/out_zero/out_take_branch/out_illegal response.
// optional: define ALU_SHADOW_CHECK_EN to add out_mismatch (local reference check of the ALU).
module alu_op_issuer import alu_ctrl_pkg::*; #(
  parameter int ALU_LAT = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_take_branch,
`ifdef ALU_SHADOW_CHECK_EN
  output logic             out_mismatch,
`endif
  output logic             out_illegal
);
  state_t state, state_n;
  br_t br, d_br;
  logic [3:0] cnt;
  logic [2:0] d_cmd;
  logic [WIDTH-1:0] d_a, d_b;
  logic d_ill, accept, capture;
  alu_op_decode u_dec (
    .instr(instr),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .cmd(d_cmd),
    .a(d_a),
    .b(d_b),
    .br(d_br),
    .illegal(d_ill)
  );
`ifdef ALU_SHADOW_CHECK_EN
  logic [WIDTH-1:0] ref_val;
  assign ref_val = alu_ref(alu_command, alu_a, alu_b);
`endif
  always_comb begin
    in_ready = rst_n && state == IDLE;
    out_valid = state == RESP;
    accept = in_valid && in_ready;
    capture = state == WAIT && cnt == 4'd0;
    state_n = state == IDLE ? (accept ? (d_ill ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
              state == RESP ? (out_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      br <= NONE;
      alu_a <= '0;
      alu_b <= '0;
      alu_command <= ALU_ADD;
      out_result <= '0;
      out_zero <= 1'b0;
      out_take_branch <= 1'b0;
      out_illegal <= 1'b0;
`ifdef ALU_SHADOW_CHECK_EN
      out_mismatch <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == WAIT) cnt <= cnt - 4'd1;
      // illegal instructions leave the ALU inputs untouched
      if (accept && !d_ill) begin
        alu_a <= d_a;
        alu_b <= d_b;
        alu_command <= d_cmd;
        br <= d_br;
        cnt <= 4'(ALU_LAT - 1);
      end
      if (accept && d_ill) begin
        out_result <= '0;
        out_zero <= 1'b0;
        out_take_branch <= 1'b0;
        out_illegal <= 1'b1;
`ifdef ALU_SHADOW_CHECK_EN
        out_mismatch <= 1'b0;
`endif
      end
      if (capture) begin
        out_result <= alu_result;
        out_zero <= alu_zero;
        out_take_branch <= br == BEQ ? alu_zero : br == BNE ? !alu_zero : 1'b0;
        out_illegal <= 1'b0;
`ifdef ALU_SHADOW_CHECK_EN
        out_mismatch <= alu_result != ref_val || alu_zero != (ref_val == '0);
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: scoreboard bench for alu_op_issuer with an ideal ALU model
module tb_alu_op_issuer;
  localparam int LAT = 1;
  typedef struct {
    logic [31:0] a, b, res;
    logic [2:0] cmd;
    logic z, tb, ill, mm;
  } exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = 0, rs_val = 0, rt_val = 0;
  logic in_ready, alu_zero, out_valid, out_zero, out_take_branch, out_illegal, bad_alu;
  logic [31:0] alu_a, alu_b, alu_result, out_result;
  logic [2:0] alu_command;
  logic [31:0] last_a = 0, last_b = 0;
  logic [2:0] last_cmd = 0;
  int total = 0, bad = 0;
  exp_t q[$];
`ifdef ALU_SHADOW_CHECK_EN
  logic out_mismatch;
  assign bad_alu = alu_command == 3'd2 && alu_a == 32'hF0F0 && alu_b == 32'h0F0F;
`else
  assign bad_alu = 1'b0;
`endif
  assign alu_result = bad_alu ? 32'd0 : alu_command == 3'd0 ? alu_a + alu_b :
                      alu_command == 3'd1 ? alu_a - alu_b : alu_command == 3'd2 ? alu_a ^ alu_b :
                      {31'd0, $signed(alu_a) < $signed(alu_b)};
  assign alu_zero = alu_result == 32'd0;
  always #5 clk = ~clk;
  alu_op_issuer #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_take_branch(out_take_branch),
`ifdef ALU_SHADOW_CHECK_EN
    .out_mismatch(out_mismatch),
`endif
    .out_illegal(out_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] a, b, input logic [2:0] cmd, input logic [31:0] res,
                              input logic z, tb, ill, mm);
    exp_t e;
    e.a = a; e.b = b; e.cmd = cmd; e.res = res; e.z = z; e.tb = tb; e.ill = ill; e.mm = mm;
    return e;
  endfunction
  task automatic check_out(input exp_t g);
    chk("out_valid", out_valid, 1);
    chk("out_result", out_result, g.res);
    chk("out_zero", out_zero, g.z);
    chk("out_take_branch", out_take_branch, g.tb);
    chk("out_illegal", out_illegal, g.ill);
    chk("in_ready_busy", in_ready, 0);
`ifdef ALU_SHADOW_CHECK_EN
    chk("out_mismatch", out_mismatch, g.mm);
`endif
  endtask
  // mode 0: release at once; 1: hold out_ready low 5 cycles; 2: hold then reset instead of accepting
  task automatic run(input logic [31:0] ins, rs, rt, input exp_t e, input int mode);
    exp_t g;
    int n;
    q.push_back(e);
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    in_valid = 1; instr = ins; rs_val = rs; rt_val = rt;
    @(posedge clk);
    #1 in_valid = 0;
    if (!e.ill) begin
      last_a = e.a; last_b = e.b; last_cmd = e.cmd;
    end
    chk("alu_a", alu_a, last_a);
    chk("alu_b", alu_b, last_b);
    chk("alu_command", alu_command, last_cmd);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("latency", n, e.ill ? 0 : LAT);
    g = q.pop_front();
    check_out(g);
    if (mode > 0) repeat (5) begin
      @(negedge clk);
      check_out(g);
      chk("alu_a_hold", alu_a, last_a);
    end
    if (mode == 2) begin
      rst_n = 0;
      #1 chk("in_ready_rst", in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1;
      last_a = 0; last_b = 0; last_cmd = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_flags", {out_zero, out_take_branch, out_illegal}, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_command", alu_command, 0);
    end else begin
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      chk("out_valid_drop", out_valid, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    exp_t ex;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_command", alu_command, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_flags", {out_zero, out_take_branch, out_illegal}, 0);
    rst_n = 1;
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 5, 7, mk(5, 7, 0, 12, 0, 0, 0, 0), 1);
    run({6'h0A, 5'd1, 5'd2, 16'hFFFF}, 32'hFFFFFFFE, 99,
        mk(32'hFFFFFFFE, 32'hFFFFFFFF, 3, 1, 0, 0, 0, 0), 0);
    run({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, mk(32'h1234, 32'h1234, 1, 0, 1, 1, 0, 0), 0);
    run({6'h05, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, mk(32'h1234, 32'h1234, 1, 0, 1, 0, 0, 0), 0);
    run({6'h3F, 26'h0}, 32'hAAAA, 32'hBBBB, mk(0, 0, 0, 0, 0, 0, 1, 0), 1);
    run({6'h0E, 5'd1, 5'd2, 16'h8001}, 32'hF0F0, 3, mk(32'hF0F0, 32'h8001, 2, 32'h70F1, 0, 0, 0, 0), 0);
    run({6'h08, 5'd1, 5'd2, 16'hFFFE}, 5, 3, mk(5, 32'hFFFFFFFE, 0, 3, 0, 0, 0, 0), 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23}, 9, 9, mk(9, 9, 1, 0, 1, 0, 0, 0), 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, 32'h80000000, 1, mk(32'h80000000, 1, 3, 1, 0, 0, 0, 0), 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 1, 2, mk(0, 0, 0, 0, 0, 0, 1, 0), 0);
`ifdef ALU_SHADOW_CHECK_EN
    ex = mk(32'hF0F0, 32'h0F0F, 2, 0, 1, 0, 0, 1);
`else
    ex = mk(32'hF0F0, 32'h0F0F, 2, 32'hFFFF, 0, 0, 0, 0);
`endif
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h26}, 32'hF0F0, 32'h0F0F, ex, 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'hFFFFFFFF, 1, mk(32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0), 2);
    run({6'h08, 5'd1, 5'd2, 16'h0010}, 32'h20, 0, mk(32'h20, 32'h10, 0, 32'h30, 0, 0, 0, 0), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
